// File: rtl/bit_timing_ctrl.sv
// bit_timing_ctrl: frames an async serial receive line using an external
// rollover counter. Detects the start edge, qualifies it at half a bit,
// issues one mid-bit strobe per data bit (LSB first), then checks the stop bit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, counter held clear, waiting for a low start edge
// START | counting half a bit; start bit must still be low at the flag
// DATA  | one strobe per bit period, DATA_BITS strobes in total
// STOP  | one more bit period; stop bit sampled high = done, low = error
module bit_timing_ctrl #(
    parameter int CNT_BITS  = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic                rx_in,
    input  logic [CNT_BITS-1:0] bit_period,
    input  logic                cnt_rollover_flag,
    output logic                cnt_clear,
    output logic                cnt_count_enable,
    output logic                cnt_save_count,
    output logic                cnt_revert_count,
    output logic [CNT_BITS-1:0] cnt_rollover_val,
    output logic                shift_strobe,
    output logic                rx_bit,
    output logic [3:0]          bit_index,
    output logic                frame_done,
    output logic                frame_error,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [3:0]          LAST_IDX = 4'(DATA_BITS - 1);
    localparam logic [CNT_BITS-1:0] PER_MIN  = CNT_BITS'(2);

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] per_q, per_nxt;
    logic [CNT_BITS-1:0] half;
    logic [3:0]          idx_q, idx_nxt;
    logic                strobe_nxt, done_nxt, err_nxt, rx_bit_nxt;
    logic [3:0]          bit_index_nxt;

    // Period is clamped to 2 so the half-bit interval is never zero.
    assign half             = per_q >> 1;
    assign busy             = (state != IDLE);
    assign cnt_save_count   = 1'b0;
    assign cnt_revert_count = 1'b0;

    // State, latched period and registered strobe/pulse outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            per_q        <= PER_MIN;
            idx_q        <= '0;
            shift_strobe <= 1'b0;
            rx_bit       <= 1'b0;
            bit_index    <= '0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_nxt;
            per_q        <= per_nxt;
            idx_q        <= idx_nxt;
            shift_strobe <= strobe_nxt;
            rx_bit       <= rx_bit_nxt;
            bit_index    <= bit_index_nxt;
            frame_done   <= done_nxt;
            frame_error  <= err_nxt;
        end
    end

    // Next-state, counter control and next values of the registered outputs.
    always_comb begin
        state_nxt        = state;
        per_nxt          = per_q;
        idx_nxt          = idx_q;
        strobe_nxt       = 1'b0;
        done_nxt         = 1'b0;
        err_nxt          = 1'b0;
        rx_bit_nxt       = rx_bit;
        bit_index_nxt    = bit_index;
        cnt_clear        = 1'b0;
        cnt_count_enable = 1'b0;
        cnt_rollover_val = '0;

        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                idx_nxt   = '0;
                if (enable && !rx_in) begin
                    state_nxt = START;
                    per_nxt   = (bit_period < PER_MIN) ? PER_MIN : bit_period;
                end
            end
            START: begin
                cnt_count_enable = 1'b1;
                cnt_rollover_val = half;
                if (cnt_rollover_flag) begin
                    if (!rx_in) begin
                        // Restart the counter so data flags land mid-bit.
                        state_nxt = DATA;
                        cnt_clear = 1'b1;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_count_enable = 1'b1;
                cnt_rollover_val = per_q;
                if (cnt_rollover_flag) begin
                    strobe_nxt    = 1'b1;
                    rx_bit_nxt    = rx_in;
                    bit_index_nxt = idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx_q + 4'd1;
                    end
                end
            end
            STOP: begin
                cnt_count_enable = 1'b1;
                cnt_rollover_val = per_q;
                if (cnt_rollover_flag) begin
                    done_nxt  = rx_in;
                    err_nxt   = !rx_in;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Receiver disable wins over everything and suppresses all pulses.
        if (!enable) begin
            state_nxt     = IDLE;
            per_nxt       = per_q;
            idx_nxt       = '0;
            strobe_nxt    = 1'b0;
            done_nxt      = 1'b0;
            err_nxt       = 1'b0;
            rx_bit_nxt    = rx_bit;
            bit_index_nxt = bit_index;
        end
    end

endmodule

// File: tb/tb_bit_timing_ctrl.sv
// Bench for bit_timing_ctrl: models the external rollover counter, drives
// serial frames, and checks strobes/pulses against an expectation queue.
module tb_bit_timing_ctrl;

    localparam int CB = 8;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          n_rst, enable, rx_in;
    logic [CB-1:0] bit_period;
    logic          cnt_rollover_flag = 1'b0;
    logic          cnt_clear, cnt_count_enable, cnt_save_count, cnt_revert_count;
    logic [CB-1:0] cnt_rollover_val;
    logic          shift_strobe, rx_bit, frame_done, frame_error, busy;
    logic [3:0]    bit_index;

    bit_timing_ctrl #(.CNT_BITS(CB), .DATA_BITS(DB)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .enable            (enable),
        .rx_in             (rx_in),
        .bit_period        (bit_period),
        .cnt_rollover_flag (cnt_rollover_flag),
        .cnt_clear         (cnt_clear),
        .cnt_count_enable  (cnt_count_enable),
        .cnt_save_count    (cnt_save_count),
        .cnt_revert_count  (cnt_revert_count),
        .cnt_rollover_val  (cnt_rollover_val),
        .shift_strobe      (shift_strobe),
        .rx_bit            (rx_bit),
        .bit_index         (bit_index),
        .frame_done        (frame_done),
        .frame_error       (frame_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // External counter model: flag pulses once every rollover_val enabled clocks.
    logic [CB-1:0] cnt = '0;
    always @(posedge clk) begin
        if (cnt_clear) begin
            cnt               <= '0;
            cnt_rollover_flag <= 1'b0;
        end else if (cnt_count_enable) begin
            if (({1'b0, cnt} + 9'd1) >= {1'b0, cnt_rollover_val}) begin
                cnt               <= '0;
                cnt_rollover_flag <= 1'b1;
            end else begin
                cnt               <= cnt + 8'd1;
                cnt_rollover_flag <= 1'b0;
            end
        end else begin
            cnt_rollover_flag <= 1'b0;
        end
    end

    typedef struct {
        int   kind;   // 0 strobe, 1 done, 2 error
        logic b;
        int   idx;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_strobe_cyc = 0;
    int   exp_per = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        int   n;
        exp_t e;
        if (n_rst) begin
            n = int'(shift_strobe) + int'(frame_done) + int'(frame_error);
            if (n > 0) chk("pulse_excl", n, 1);
            if (n == 1) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {shift_strobe, frame_done, frame_error}, 0);
                end else begin
                    e = q.pop_front();
                    if (shift_strobe) begin
                        chk("kind_strobe", 0, e.kind);
                        chk("rx_bit", rx_bit, e.b);
                        chk("bit_index", bit_index, e.idx);
                        if (e.idx != 0) chk("strobe_spacing", cyc - last_strobe_cyc, exp_per);
                        last_strobe_cyc = cyc;
                    end else if (frame_done) begin
                        chk("kind_done", 1, e.kind);
                    end else begin
                        chk("kind_error", 2, e.kind);
                    end
                end
            end
        end
    end

    // mode 0: normal, 1: drop enable during data bit 3, 2: reset during stop bit
    task automatic send_frame(input int per, input logic [7:0] data, input logic stop_val,
                              input int mode, input int bp_mid);
        exp_t e;
        bit   seen;
        for (int k = 0; k < DB; k++) begin
            e.kind = 0; e.b = data[k]; e.idx = k;
            q.push_back(e);
        end
        e.kind = stop_val ? 1 : 2; e.b = 1'b0; e.idx = 0;
        q.push_back(e);
        exp_per = per;

        rx_in = 1'b0;
        repeat (per + 3) tick();
        if (bp_mid >= 0) bit_period = CB'(bp_mid);

        for (int k = 0; k < DB; k++) begin
            rx_in = data[k];
            if (mode == 1 && k == 3) begin
                repeat (2) tick();
                enable = 1'b0;
                rx_in  = 1'b1;
                tick();
                tick();
                chk("abort_busy", busy, 0);
                chk("abort_clear", cnt_clear, 1);
                chk("abort_strobe", shift_strobe, 0);
                q.delete();
                enable = 1'b1;
                repeat (2 * per) tick();
                return;
            end
            repeat (per) tick();
        end

        rx_in = stop_val;
        if (mode == 2) begin
            repeat (2) tick();
            n_rst = 1'b0;
            tick();
            chk("rst_busy", busy, 0);
            chk("rst_pulses", {shift_strobe, frame_done, frame_error}, 0);
            chk("rst_outs", {rx_bit, bit_index, cnt_count_enable, cnt_rollover_val}, 0);
            chk("rst_clear", cnt_clear, 1);
            q.delete();
            n_rst = 1'b1;
            rx_in = 1'b1;
            repeat (3 * per) tick();
            return;
        end

        seen = 1'b0;
        for (int t = 0; t < 3 * per + 10 && !seen; t++) begin
            tick();
            if (frame_done || frame_error) seen = 1'b1;
        end
        rx_in = 1'b1;
        if (!seen) begin
            chk("frame_end_timeout", 0, 1);
            q.delete();
        end
    endtask

    initial begin
        n_rst      = 1'b0;
        enable     = 1'b0;
        rx_in      = 1'b1;
        bit_period = 8'd16;
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_clear", cnt_clear, 1);
        chk("reset_pulses", {shift_strobe, frame_done, frame_error}, 0);
        chk("reset_outs", {rx_bit, bit_index, cnt_count_enable, cnt_save_count,
                           cnt_revert_count, cnt_rollover_val}, 0);
        n_rst  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();

        // Nominal frame 0xA5
        send_frame(16, 8'hA5, 1'b1, 0, -1);
        repeat (5) tick();

        // False start: glitch shorter than half a bit
        rx_in = 1'b0;
        repeat (4) tick();
        rx_in = 1'b1;
        chk("false_start_busy", busy, 1);
        chk("false_start_half", cnt_rollover_val, 8);
        repeat (32) tick();
        chk("false_start_idle", busy, 0);

        // Framing error
        bit_period = 8'd10;
        send_frame(10, 8'h3C, 1'b0, 0, -1);
        repeat (5) tick();

        // Enable drop mid-data, then a clean frame
        bit_period = 8'd16;
        send_frame(16, 8'hC3, 1'b1, 1, -1);
        send_frame(16, 8'h5A, 1'b1, 0, -1);
        repeat (5) tick();

        // Period clamp and mid-frame period change
        bit_period = 8'd0;
        send_frame(2, 8'h96, 1'b1, 0, -1);
        repeat (5) tick();
        bit_period = 8'd1;
        send_frame(2, 8'h69, 1'b1, 0, 16);
        repeat (5) tick();
        send_frame(16, 8'h0F, 1'b1, 0, -1);
        repeat (5) tick();

        // Reset during stop, then back-to-back frames
        send_frame(16, 8'hFF, 1'b1, 2, -1);
        send_frame(16, 8'h81, 1'b1, 0, -1);
        send_frame(16, 8'h7E, 1'b1, 0, -1);
        repeat (40) tick();

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
